// File: rtl/demux_deser8.sv
// demux_deser8: 1:8 serial-to-parallel demultiplexer with a ready/valid byte output.
// Each accepted bit goes into the shadow register slot selected by idx, which
// follows the transmitter's mux select (0..7). A completed byte is handed to
// the output register. A new start in mid-frame aborts that frame. A completion
// that finds the output still full and not accepted is dropped and flagged.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for din_valid & start (bit 0 of a frame)
// SHIFT | frame partially received; idx is the next bit position
module demux_deser8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    input  logic       start,
    output logic [2:0] sel,
    output logic       busy,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       complete;
    logic [7:0] word;

    // The completed word takes bit 7 directly from din on the completing cycle.
    assign word = {din, shadow_q[6:0]};

    // Next-state logic: frame sequencing, then the output handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        complete     = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_valid && start) begin
                    shadow_d[0] = din;
                    idx_d       = 3'd1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (din_valid) begin
                    if (start) begin
                        frame_err_d = 1'b1;
                        shadow_d[0] = din;
                        idx_d       = 3'd1;
                    end else begin
                        shadow_d[idx_q] = din;
                        if (idx_q == 3'd7) begin
                            complete = 1'b1;
                            idx_d    = 3'd0;
                            state_d  = IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase

        // A consumed byte frees the output; a completion in the same cycle refills it.
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
        if (complete) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset that discards partial and pending data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            shadow_q     <= 8'h00;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sel        = idx_q;
    assign busy       = (state_q == SHIFT);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/demux_deser8.md
# demux_deser8

Receive-side partner of the 8:1 bit-select multiplexer. The transmitter walks its 3-bit select 0→7, one bit per valid strobe; this block walks a matching 3-bit index and steers each arriving bit into that position of an 8-bit shadow register (a 1:8 demultiplex). It then presents the completed byte on a ready/valid output port for downstream game logic.

## Interface
Parameters:
- none; word width is fixed at 8 and index width at 3.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a bit this cycle.
- start  input  1  frame start; meaningful only together with din_valid; marks the bit as bit 0.
- sel  output  3  index the next accepted bit will be written to; mirrors the transmitter's mux select.
- busy  output  1  high while a frame is partially received (state SHIFT).
- dout  output  8  assembled byte; dout[k] = k-th bit of the frame (LSB first).
- dout_valid  output  1  dout holds an unconsumed byte.
- dout_ready  input  1  consumer accepts dout this cycle when dout_valid is high.
- frame_err  output  1  one-cycle pulse: frame aborted by a new start.
- overrun  output  1  one-cycle pulse: completed byte dropped because the output was still full.

## Operation
- State machine with two states: IDLE and SHIFT. Internal 8-bit shadow register and 3-bit index idx; sel = idx.
- IDLE:
  - din_valid & start → shadow[0] ← din, idx ← 1, go to SHIFT.
  - din_valid without start → ignored.
  - start without din_valid → ignored.
- SHIFT, on din_valid & !start:
  - shadow[idx] ← din.
  - If idx = 7: the frame is complete; idx ← 0 and go to IDLE. Otherwise idx ← idx + 1.
  - idx wraps 7→0 only through completion.
- SHIFT, on din_valid & start: the current frame is aborted.
  - Pulse frame_err.
  - shadow[0] ← din, idx ← 1, stay in SHIFT.
  - No byte is emitted for the aborted frame.
- Completion (word = shadow with bit 7 = current din):
  - dout_valid low → dout ← word, dout_valid ← 1.
  - dout_valid high & dout_ready high (same cycle) → old byte is consumed; dout ← word, dout_valid stays 1.
  - dout_valid high & dout_ready low → word is discarded, dout unchanged, overrun pulses.
- Output handshake without a completion: dout_valid & dout_ready → dout_valid ← 0. dout holds its value (don't-care once invalid).
- dout is stable while dout_valid is high and not accepted.
- busy = (state == SHIFT).

## Timing
- Reset values (the cycle after reset is high at an edge):
  - state IDLE, idx/sel = 0, shadow = 0, dout = 8'h00.
  - dout_valid = 0, busy = 0, frame_err = 0, overrun = 0.
- Reset overrides all inputs. Reset in mid-frame discards partial data and any pending dout, and produces no frame_err.
- Latency: dout_valid rises on the clock edge that samples bit 7, i.e. visible the cycle after bit 7 is presented. Back-to-back frames at one bit per cycle give a byte every 8 cycles.
- sel updates on the same edge that accepts a bit, so it is combinationally consistent with the next expected index.
- frame_err and overrun are registered, high for exactly one cycle after the offending edge.
- din_valid gaps of any length inside a frame are legal. State and idx hold, and there is no timeout.

## Test plan
- Nominal frame:
  - Stimulus: start on bit 0, then bits 1,0,1,1,0,0,1,0 (bit0..bit7) on 8 consecutive din_valid cycles.
  - Response: dout = 8'h4D, dout_valid high one cycle after bit 7; sel sequence 1..7 then 0; busy high for 7 cycles.
- Gapped input:
  - Stimulus: same frame with din_valid low for 3 cycles between bits 3 and 4, and dout_ready held low.
  - Response: dout = 8'h4D; dout_valid stays high until dout_ready pulses, then drops the next cycle.
- Abort:
  - Stimulus: start plus 4 bits, then a new start with 8 bits encoding 8'hA5.
  - Response: frame_err pulses once; only one byte, 8'hA5, is emitted.
- Overrun and simultaneous handshake:
  - Stimulus: two back-to-back frames 8'h11 then 8'h22 with dout_ready low; then repeat with dout_ready high on the completion cycle of the second frame.
  - Response, ready low: overrun pulses once and dout stays 8'h11.
  - Response, ready high: dout = 8'h22, dout_valid never drops, no overrun.
- Ignored input:
  - Stimulus: din_valid without start in IDLE; start without din_valid.
  - Response: sel stays 0, busy stays 0, no outputs change.
- Reset mid-frame:
  - Stimulus: reset asserted after bit 5, with a pending dout = 8'h33.
  - Response: next cycle sel = 0, busy = 0, dout_valid = 0, dout = 8'h00, no frame_err. A following full frame 8'hC3 is received correctly.
